// File: rtl/ahb_master_arb_if.sv
// rtl/ahb_master_arb_if.sv - bundled master-side, slave-side and handshake signals of the two-master arbiter
interface ahb_master_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              m0_bus_req;
    logic              m0_bus_ack;
    logic [ADDR_W-1:0] m0_haddr;
    logic              m0_hwrite;
    logic [2:0]        m0_hsize;
    logic [2:0]        m0_hburst;
    logic [1:0]        m0_htrans;
    logic              m0_hmastlock;
    logic [DATA_W-1:0] m0_hwdata;
    logic              m0_hready;
    logic              m0_hresp;
    logic [DATA_W-1:0] m0_hrdata;

    logic              m1_bus_req;
    logic              m1_bus_ack;
    logic [ADDR_W-1:0] m1_haddr;
    logic              m1_hwrite;
    logic [2:0]        m1_hsize;
    logic [2:0]        m1_hburst;
    logic [1:0]        m1_htrans;
    logic              m1_hmastlock;
    logic [DATA_W-1:0] m1_hwdata;
    logic              m1_hready;
    logic              m1_hresp;
    logic [DATA_W-1:0] m1_hrdata;

    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [1:0]        htrans;
    logic              hmastlock;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    // The arbiter sits behind the slave modport; masters and the SoC slave port use the master view.
    modport slave (
        input  m0_bus_req, m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_htrans, m0_hmastlock, m0_hwdata,
        output m0_bus_ack, m0_hready, m0_hresp, m0_hrdata,
        input  m1_bus_req, m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_htrans, m1_hmastlock, m1_hwdata,
        output m1_bus_ack, m1_hready, m1_hresp, m1_hrdata,
        output haddr, hwrite, hsize, hburst, htrans, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport master (
        output m0_bus_req, m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_htrans, m0_hmastlock, m0_hwdata,
        input  m0_bus_ack, m0_hready, m0_hresp, m0_hrdata,
        output m1_bus_req, m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_htrans, m1_hmastlock, m1_hwdata,
        input  m1_bus_ack, m1_hready, m1_hresp, m1_hrdata,
        input  haddr, hwrite, hsize, hburst, htrans, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_master_arb.sv
// rtl/ahb_master_arb.sv - two-master AHB-Lite arbiter with lock-aware, non-preemptive ownership
module ahb_master_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter bit RR_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               hreset_n,
    ahb_master_arb_if.slave    bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    owner_e owner_q;
    owner_e owner_d;
    owner_e last_q;
    owner_e last_d;
    owner_e dp_id_q;
    owner_e winner;
    logic   dp_valid_q;
    logic   rel_m0;
    logic   rel_m1;
    logic   arbitrate;

    logic [ADDR_W-1:0] haddr_mux;
    logic              hwrite_mux;
    logic [2:0]        hsize_mux;
    logic [2:0]        hburst_mux;
    logic [1:0]        htrans_mux;
    logic              hmastlock_mux;
    logic [DATA_W-1:0] hwdata_mux;

    // A master may only let go at an idle, unlocked, completed transfer boundary.
    assign rel_m0 = !bus.m0_bus_req && (bus.m0_htrans == 2'b00) && !bus.m0_hmastlock && bus.hready;
    assign rel_m1 = !bus.m1_bus_req && (bus.m1_htrans == 2'b00) && !bus.m1_hmastlock && bus.hready;

    always_comb begin
        winner = OWN_NONE;
        if (bus.m0_bus_req && bus.m1_bus_req) begin
            winner = (RR_EN && (last_q == OWN_M0)) ? OWN_M1 : OWN_M0;
        end else if (bus.m0_bus_req) begin
            winner = OWN_M0;
        end else if (bus.m1_bus_req) begin
            winner = OWN_M1;
        end
    end

    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        arbitrate = 1'b0;
        case (owner_q)
            OWN_NONE: arbitrate = 1'b1;
            OWN_M0:   arbitrate = rel_m0;
            OWN_M1:   arbitrate = rel_m1;
            default:  arbitrate = 1'b1;
        endcase
        // Release and re-grant share one edge, so a waiting master takes over with no dead cycle.
        if (arbitrate) begin
            owner_d = winner;
            if (winner != OWN_NONE) begin
                last_d = winner;
            end
        end
    end

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            owner_q    <= OWN_NONE;
            last_q     <= OWN_M1;
            dp_valid_q <= 1'b0;
            dp_id_q    <= OWN_M0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            if (bus.hready) begin
                dp_valid_q <= (owner_q != OWN_NONE) && htrans_mux[1];
                dp_id_q    <= owner_q;
            end
        end
    end

    always_comb begin
        haddr_mux     = '0;
        hwrite_mux    = 1'b0;
        hsize_mux     = 3'b000;
        hburst_mux    = 3'b000;
        htrans_mux    = 2'b00;
        hmastlock_mux = 1'b0;
        case (owner_q)
            OWN_M0: begin
                haddr_mux     = bus.m0_haddr;
                hwrite_mux    = bus.m0_hwrite;
                hsize_mux     = bus.m0_hsize;
                hburst_mux    = bus.m0_hburst;
                htrans_mux    = bus.m0_htrans;
                hmastlock_mux = bus.m0_hmastlock;
            end
            OWN_M1: begin
                haddr_mux     = bus.m1_haddr;
                hwrite_mux    = bus.m1_hwrite;
                hsize_mux     = bus.m1_hsize;
                hburst_mux    = bus.m1_hburst;
                htrans_mux    = bus.m1_htrans;
                hmastlock_mux = bus.m1_hmastlock;
            end
            default: begin
                haddr_mux     = '0;
                hwrite_mux    = 1'b0;
                hsize_mux     = 3'b000;
                hburst_mux    = 3'b000;
                htrans_mux    = 2'b00;
                hmastlock_mux = 1'b0;
            end
        endcase
    end

    always_comb begin
        hwdata_mux = '0;
        if (dp_valid_q && (dp_id_q == OWN_M0)) begin
            hwdata_mux = bus.m0_hwdata;
        end else if (dp_valid_q && (dp_id_q == OWN_M1)) begin
            hwdata_mux = bus.m1_hwdata;
        end
    end

    assign bus.haddr     = haddr_mux;
    assign bus.hwrite    = hwrite_mux;
    assign bus.hsize     = hsize_mux;
    assign bus.hburst    = hburst_mux;
    assign bus.htrans    = htrans_mux;
    assign bus.hmastlock = hmastlock_mux;
    assign bus.hwdata    = hwdata_mux;

    assign bus.m0_bus_ack = (owner_q == OWN_M0);
    assign bus.m1_bus_ack = (owner_q == OWN_M1);

    assign bus.m0_hready = bus.hready;
    assign bus.m1_hready = bus.hready;
    assign bus.m0_hrdata = bus.hrdata;
    assign bus.m1_hrdata = bus.hrdata;

    // Only the data-phase owner sees an error; the bystander always reads OKAY.
    assign bus.m0_hresp = dp_valid_q && (dp_id_q == OWN_M0) && bus.hresp;
    assign bus.m1_hresp = dp_valid_q && (dp_id_q == OWN_M1) && bus.hresp;

endmodule

// File: tb/tb_ahb_master_arb.sv
// tb/tb_ahb_master_arb.sv - directed bench for ahb_master_arb in round-robin and fixed-priority builds
module tb_ahb_master_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ahb_master_arb_if #(.ADDR_W(64), .DATA_W(64)) bus_rr ();
    ahb_master_arb_if #(.ADDR_W(64), .DATA_W(64)) bus_fp ();

    ahb_master_arb #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b1)) dut_rr (
        .clk      (clk),
        .hreset_n (rst_n),
        .bus      (bus_rr.slave)
    );

    ahb_master_arb #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b0)) dut_fp (
        .clk      (clk),
        .hreset_n (rst_n),
        .bus      (bus_fp.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_rr.m0_bus_req = 0; bus_rr.m0_haddr = '0; bus_rr.m0_hwrite = 0; bus_rr.m0_hsize = 0;
        bus_rr.m0_hburst = 0; bus_rr.m0_htrans = 0; bus_rr.m0_hmastlock = 0; bus_rr.m0_hwdata = '0;
        bus_rr.m1_bus_req = 0; bus_rr.m1_haddr = '0; bus_rr.m1_hwrite = 0; bus_rr.m1_hsize = 0;
        bus_rr.m1_hburst = 0; bus_rr.m1_htrans = 0; bus_rr.m1_hmastlock = 0; bus_rr.m1_hwdata = '0;
        bus_rr.hready = 1; bus_rr.hresp = 1; bus_rr.hrdata = '0;
        bus_fp.m0_bus_req = 0; bus_fp.m0_haddr = '0; bus_fp.m0_hwrite = 0; bus_fp.m0_hsize = 0;
        bus_fp.m0_hburst = 0; bus_fp.m0_htrans = 0; bus_fp.m0_hmastlock = 0; bus_fp.m0_hwdata = '0;
        bus_fp.m1_bus_req = 0; bus_fp.m1_haddr = '0; bus_fp.m1_hwrite = 0; bus_fp.m1_hsize = 0;
        bus_fp.m1_hburst = 0; bus_fp.m1_htrans = 0; bus_fp.m1_hmastlock = 0; bus_fp.m1_hwdata = '0;
        bus_fp.hready = 1; bus_fp.hresp = 0; bus_fp.hrdata = '0;

        // Reset state (hresp held high to show it is not routed with no data phase)
        tick(); tick();
        chk("rst_ack0", bus_rr.m0_bus_ack, 0);
        chk("rst_ack1", bus_rr.m1_bus_ack, 0);
        chk("rst_htrans", bus_rr.htrans, 0);
        chk("rst_haddr", bus_rr.haddr, 0);
        chk("rst_hwdata", bus_rr.hwdata, 0);
        chk("rst_m0_hresp", bus_rr.m0_hresp, 0);
        bus_rr.hresp = 0;
        rst_n = 1;

        // 1. Single master write
        bus_rr.m0_bus_req = 1;
        chk("t1_ack0_before", bus_rr.m0_bus_ack, 0);
        tick();
        chk("t1_ack0", bus_rr.m0_bus_ack, 1);
        chk("t1_ack1", bus_rr.m1_bus_ack, 0);
        bus_rr.m0_htrans = 2'b10; bus_rr.m0_haddr = 64'h8000_0000; bus_rr.m0_hwrite = 1; bus_rr.m0_hsize = 3;
        #1;
        chk("t1_haddr", bus_rr.haddr, 64'h8000_0000);
        chk("t1_htrans", bus_rr.htrans, 2'b10);
        chk("t1_hwrite", bus_rr.hwrite, 1);
        tick();
        bus_rr.m0_htrans = 2'b00; bus_rr.m0_hwdata = 64'h1122334455667788;
        #1;
        chk("t1_hwdata", bus_rr.hwdata, 64'h1122334455667788);
        chk("t1_htrans_idle", bus_rr.htrans, 0);
        chk("t1_ack1_still0", bus_rr.m1_bus_ack, 0);
        bus_rr.m0_bus_req = 0;
        tick();
        chk("t1_release_ack0", bus_rr.m0_bus_ack, 0);
        chk("t1_dp_clear_hwdata", bus_rr.hwdata, 0);

        // 2. Round-robin contention from a fresh reset
        rst_n = 0; #1; rst_n = 1;
        bus_rr.m0_bus_req = 1; bus_rr.m1_bus_req = 1;
        tick();
        chk("t2_first_ack0", bus_rr.m0_bus_ack, 1);
        chk("t2_first_ack1", bus_rr.m1_bus_ack, 0);
        bus_rr.m0_bus_req = 0;
        tick();
        chk("t2_handover_ack1", bus_rr.m1_bus_ack, 1);
        chk("t2_handover_ack0", bus_rr.m0_bus_ack, 0);
        bus_rr.m1_bus_req = 0;
        tick();
        chk("t2_idle_ack1", bus_rr.m1_bus_ack, 0);
        bus_rr.m0_bus_req = 1; bus_rr.m1_bus_req = 1;
        tick();
        chk("t2_second_ack0", bus_rr.m0_bus_ack, 1);
        chk("t2_second_ack1", bus_rr.m1_bus_ack, 0);
        bus_rr.m0_bus_req = 0;
        tick();
        chk("t2_back_to_m1", bus_rr.m1_bus_ack, 1);

        // 3. M1 read with three wait states and an error on completion; M0 waits
        bus_rr.m1_htrans = 2'b10; bus_rr.m1_hwrite = 0; bus_rr.m1_haddr = 64'h1000;
        #1;
        chk("t3_haddr", bus_rr.haddr, 64'h1000);
        tick();
        bus_rr.m1_htrans = 2'b00; bus_rr.hready = 0; bus_rr.m0_bus_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_ack1", bus_rr.m1_bus_ack, 1);
            chk("t3_stall_ack0", bus_rr.m0_bus_ack, 0);
            chk("t3_stall_m0_hready", bus_rr.m0_hready, 0);
        end
        bus_rr.hready = 1; bus_rr.hresp = 1; bus_rr.hrdata = 64'hCAFE_F00D_0000_0001;
        #1;
        chk("t3_m1_hresp", bus_rr.m1_hresp, 1);
        chk("t3_m0_hresp", bus_rr.m0_hresp, 0);
        chk("t3_m1_hrdata", bus_rr.m1_hrdata, 64'hCAFE_F00D_0000_0001);
        chk("t3_m0_hrdata", bus_rr.m0_hrdata, 64'hCAFE_F00D_0000_0001);
        tick();
        bus_rr.hresp = 0;
        chk("t3_err_keeps_owner", bus_rr.m1_bus_ack, 1);
        bus_rr.m1_bus_req = 0;
        tick();
        chk("t3_handover_ack0", bus_rr.m0_bus_ack, 1);

        // 4. Locked INCR4 from M0; req drops mid-burst while M1 waits
        bus_rr.m1_bus_req = 1;
        bus_rr.m0_htrans = 2'b10; bus_rr.m0_hburst = 3'b011; bus_rr.m0_hmastlock = 1;
        #1;
        chk("t4_hmastlock", bus_rr.hmastlock, 1);
        chk("t4_hburst", bus_rr.hburst, 3'b011);
        tick();
        bus_rr.m0_htrans = 2'b11; bus_rr.m0_bus_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_burst_ack0", bus_rr.m0_bus_ack, 1);
            chk("t4_burst_ack1", bus_rr.m1_bus_ack, 0);
        end
        bus_rr.m0_htrans = 2'b00;
        tick();
        chk("t4_locked_idle_ack0", bus_rr.m0_bus_ack, 1);
        bus_rr.m0_hmastlock = 0; bus_rr.hready = 0;
        tick();
        chk("t4_stalled_ack0", bus_rr.m0_bus_ack, 1);
        bus_rr.hready = 1;
        tick();
        chk("t4_handover_ack1", bus_rr.m1_bus_ack, 1);
        chk("t4_handover_ack0", bus_rr.m0_bus_ack, 0);

        // 6. Asynchronous reset during an M1 write data phase
        bus_rr.m1_htrans = 2'b10; bus_rr.m1_hwrite = 1; bus_rr.m1_haddr = 64'h2000;
        tick();
        bus_rr.m1_htrans = 2'b00; bus_rr.m1_hwdata = 64'h0000_0000_DEAD_BEEF;
        #1;
        chk("t6_hwdata_live", bus_rr.hwdata, 64'h0000_0000_DEAD_BEEF);
        bus_rr.m1_htrans = 2'b10;
        #1;
        rst_n = 0;
        #1;
        chk("t6_ack0", bus_rr.m0_bus_ack, 0);
        chk("t6_ack1", bus_rr.m1_bus_ack, 0);
        chk("t6_htrans", bus_rr.htrans, 0);
        chk("t6_hwdata", bus_rr.hwdata, 0);
        bus_rr.m1_bus_req = 0; bus_rr.m1_htrans = 2'b00;
        tick();
        rst_n = 1;

        // 5. Fixed priority instance
        chk("t5_idle_htrans", bus_fp.htrans, 0);
        bus_fp.m0_bus_req = 1; bus_fp.m1_bus_req = 1;
        tick();
        chk("t5_first_ack0", bus_fp.m0_bus_ack, 1);
        bus_fp.m0_bus_req = 0; bus_fp.m1_bus_req = 0;
        tick();
        chk("t5_idle_ack0", bus_fp.m0_bus_ack, 0);
        bus_fp.m0_bus_req = 1; bus_fp.m1_bus_req = 1;
        tick();
        chk("t5_regrant_ack0", bus_fp.m0_bus_ack, 1);
        chk("t5_regrant_ack1", bus_fp.m1_bus_ack, 0);
        bus_fp.m0_bus_req = 0;
        tick();
        chk("t5_m1_when_m0_off", bus_fp.m1_bus_ack, 1);
        bus_fp.m0_bus_req = 1;
        tick();
        chk("t5_no_preempt", bus_fp.m1_bus_ack, 1);
        bus_fp.m1_bus_req = 0;
        tick();
        chk("t5_back_to_m0", bus_fp.m0_bus_ack, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_master_arb.md
# ahb_master_arb

Two-master AHB-Lite arbiter placed directly downstream of the CPU bus interface unit. It consumes the BIU's `bus_master_req`/`bus_master_ack` handshake and AHB master signals on port 0, and a second master (DMA/debug) on port 1. It grants one owner at a time and multiplexes address- and data-phase signals onto the single SoC AHB master port. Ownership is held across locked sequences and released only at a clean transfer boundary.

## Interface

Parameters:
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width.
- `RR_EN`, 1: 1 = round-robin arbitration; 0 = fixed priority, M0 wins.

Ports:
- `clk` in 1: single clock, rising edge.
- `hreset_n` in 1: reset, asynchronous, active-low.
- `m{0,1}_bus_req` in 1: master requests bus ownership.
- `m{0,1}_bus_ack` out 1: master owns the address phase.
- `m{0,1}_haddr` in ADDR_W: master AHB address.
- `m{0,1}_hwrite` in 1: master AHB write flag.
- `m{0,1}_hsize` in 3: master AHB transfer size.
- `m{0,1}_hburst` in 3: master AHB burst type.
- `m{0,1}_htrans` in 2: master AHB transfer type.
- `m{0,1}_hmastlock` in 1: master AHB lock.
- `m{0,1}_hwdata` in DATA_W: master AHB write data.
- `m{0,1}_hready` out 1: broadcast copy of `hready`.
- `m{0,1}_hresp` out 1: `hresp` to the data-phase owner; 0 to the other master.
- `m{0,1}_hrdata` out DATA_W: broadcast copy of `hrdata`.
- `haddr`, `hwrite`, `hsize`, `hburst`, `htrans`, `hmastlock` out (ADDR_W, 1, 3, 3, 2, 1): address-phase signals to the slave side.
- `hwdata` out DATA_W: write data to the slave side.
- `hready` in 1: slave-side ready.
- `hresp` in 1: slave-side response.
- `hrdata` in DATA_W: slave-side read data.

## Operation

Registered state:
- `owner_q`: one of NONE, M0, M1.
- `dp_valid_q`, `dp_id_q`: data-phase owner.
- `last_q`: last granted master, used for round-robin.

Address-phase mux:
- `m{x}_bus_ack = (owner_q == Mx)`.
- When `owner_q == Mx`, the slave-side address-phase outputs carry the Mx signals.
- When `owner_q == NONE`: `htrans=2'b00`, `haddr=0`, `hwrite=0`, `hsize=0`, `hburst=0`, `hmastlock=0`.

Arbitration, evaluated when `owner_q == NONE` or on a release edge:
- Candidates are masters with `bus_req=1`. If there are none, the next state is NONE.
- Fixed priority (`RR_EN=0`): M0 wins.
- Round-robin (`RR_EN=1`): the master that is not `last_q` wins if both request.
- On a grant, `owner_q` and `last_q` both load the winner.

Release condition for the current owner Mx, evaluated on a rising edge. All of the following must hold:
- `mx_bus_req=0`
- `mx_htrans=2'b00`
- `mx_hmastlock=0`
- `hready=1`

Ownership is never revoked while `bus_req` is held, even if the other master is waiting (no preemption).

Release edge: `owner_q` loads the arbitration result among the requesters. It may hand straight to the other master or return to NONE. The releasing master is eligible only if its own req is 1, which cannot happen because release requires req=0.

Data-phase tracking, on each edge with `hready=1`:
- `dp_valid_q <= (owner_q != NONE) && htrans[1]`.
- `dp_id_q <= owner_q`.
- When `hready=0`, both hold.

Data-phase routing:
- `hwdata` = `m{dp_id_q}_hwdata` if `dp_valid_q`, else 0.
- `hresp` goes to `m{dp_id_q}_hresp` only when `dp_valid_q`; all other `hresp` outputs are 0.

Other rules:
- A release requires `htrans=IDLE` with `hready=1`, so no data phase from the old owner remains pending after a handover.
- A slave ERROR response (`hresp=1`) does not change ownership; the master decides whether to retry or go idle.
- Reset asserted mid-transfer forces all registers to their reset values immediately, with no completion of the outstanding transfer.

## Timing

- Reset values: `owner_q=NONE`, `dp_valid_q=0`, `dp_id_q=M0`, `last_q=M1` (so M0 wins the first round-robin tie). Consequences: all acks 0, `htrans=IDLE`, `haddr=0`, `hwdata=0`, `m*_hresp=0`.
- Grant latency from idle: req seen at edge N gives ack high from edge N through N+1. The master's first NONSEQ is driven in the cycle after ack rises.
- Handover: the release edge and the new grant are the same edge, giving zero dead cycles between owners.
- While `hready=0`: `owner_q` and the data-phase registers hold, and the address-phase outputs stay muxed from the same owner.
- Locked sequence: while `hmastlock=1`, the owner keeps the bus even if `bus_req` drops.
- Both requests arriving on the same edge from idle: M0 is granted (reset `last_q=M1`). On the next arbitration M1 wins if it is still requesting.

## Test plan

1. Single master, from reset: M0 asserts req → `m0_bus_ack=1` one edge later. Then write NONSEQ `haddr=0x8000_0000`, `hwdata=0x1122334455667788` → `haddr` appears in the address phase and `hwdata` in the next cycle; `m1_bus_ack` stays 0 throughout.
2. Simultaneous req, `RR_EN=1`:
   - M0 and M1 assert req on the same edge → M0 is granted.
   - M0 drops req with `htrans=IDLE` and `hready=1` → `m1_bus_ack=1` on the same edge `m0_bus_ack` falls.
   - Next contention → M0 wins.
3. Wait states: M1 read with `hready` low for 3 cycles and `hresp=1` on the completing cycle → `m1_hresp=1`, `m0_hresp=0`, `owner_q` unchanged through all stall cycles.
4. Locked sequence: M0 runs a 4-beat INCR4 with `hmastlock=1` and drops req mid-burst while M1 requests → no handover until the burst ends and `hmastlock=0`, `htrans=IDLE`, `hready=1`.
5. Fixed priority (`RR_EN=0`): both masters request continuously and M0 releases then re-requests → M0 is re-granted at the next arbitration, and M1 is granted only when M0's req is 0.
6. Reset mid-transfer: assert `hreset_n=0` during an M1 data phase → both acks 0, `htrans=IDLE`, `hwdata=0` immediately (asynchronously).
